// File: rtl/cpu_pipeline.sv
// UART GCD sequencer: receives two operands over 8N1 serial, computes their GCD by
// repeated subtraction, returns the result on UART and shows it on LED and two hex digits.
module cpu_pipeline #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic [7:0]  LED,
    output logic [17:0] TUBE
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] RXS_IDLE  = 2'd0;
    localparam logic [1:0] RXS_START = 2'd1;
    localparam logic [1:0] RXS_DATA  = 2'd2;
    localparam logic [1:0] RXS_STOP  = 2'd3;

    localparam logic [1:0] ST_RX_A = 2'd0;
    localparam logic [1:0] ST_RX_B = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_TX   = 2'd3;

    logic             rx_meta, rx_sync, rx_prev;
    logic [1:0]       rx_st;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    // rx_valid is a one-cycle strobe qualifying rx_data; there is no ready, so a
    // byte that lands while the sequencer is in CALC or TX is simply dropped.
    logic             rx_valid;
    logic [7:0]       rx_data;

    logic [1:0]       state;
    logic [7:0]       a_r, b_r, led_r;
    logic             calc_done;
    logic [7:0]       calc_res;
    logic [9:0]       tx_frame;
    logic [3:0]       tx_idx;
    logic [CNT_W-1:0] tx_cnt;
    logic             tx_line;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_st    <= RXS_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_meta  <= UART_RX;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            case (rx_st)
                RXS_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_st  <= RXS_START;
                        rx_cnt <= '0;
                    end
                end
                RXS_START: begin
                    // A line back high at mid start bit was only a glitch.
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        rx_st  <= rx_sync ? RXS_IDLE : RXS_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RXS_DATA: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) rx_st <= RXS_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == DIV_M1) begin
                        rx_cnt <= '0;
                        rx_st  <= RXS_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shift;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign calc_done = (a_r == 8'd0) || (b_r == 8'd0) || (a_r == b_r);
    assign calc_res  = (a_r == 8'd0) ? b_r : a_r;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RX_A;
            a_r      <= '0;
            b_r      <= '0;
            led_r    <= '0;
            tx_frame <= '1;
            tx_idx   <= '0;
            tx_cnt   <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (state)
                ST_RX_A: begin
                    if (rx_valid) begin
                        a_r   <= rx_data;
                        state <= ST_RX_B;
                    end
                end
                ST_RX_B: begin
                    if (rx_valid) begin
                        b_r   <= rx_data;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Finishing edge also drives the start bit, so it appears next cycle.
                    if (calc_done) begin
                        led_r    <= calc_res;
                        tx_frame <= {1'b1, calc_res, 1'b0};
                        tx_line  <= 1'b0;
                        tx_idx   <= '0;
                        tx_cnt   <= '0;
                        state    <= ST_TX;
                    end else if (a_r > b_r) begin
                        a_r <= a_r - b_r;
                    end else begin
                        b_r <= b_r - a_r;
                    end
                end
                default: begin
                    if (tx_cnt == DIV_M1) begin
                        tx_cnt <= '0;
                        if (tx_idx == 4'd9) begin
                            tx_line <= 1'b1;
                            state   <= ST_RX_A;
                        end else begin
                            tx_idx   <= tx_idx + 4'd1;
                            tx_line  <= tx_frame[1];
                            tx_frame <= {1'b1, tx_frame[9:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    assign UART_TX = tx_line;
    assign LED     = led_r;
    assign TUBE    = {hex_seg(led_r[7:4]), hex_seg(led_r[3:0]), 4'b1100};
endmodule

// File: tb/tb_cpu_pipeline.sv
// Bench for cpu_pipeline: serial driver, frame receiver, GCD model with expected queue.
// The baud rate is raised so one bit is 16 clocks, keeping the run short.
module tb_cpu_pipeline;
    localparam int DIV = 16;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [7:0]  led;
    logic [17:0] tube;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       chk_en   = 1'b0;
    logic       tx_quiet = 1'b1;
    logic [7:0] led_exp  = 8'h00;

    cpu_pipeline #(.CLK_FREQ(100_000_000), .BAUD(6_250_000)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .UART_RX (uart_rx),
        .UART_TX (uart_tx),
        .LED     (led),
        .TUBE    (tube)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gcd_model(input logic [7:0] a, input logic [7:0] b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    function automatic logic [17:0] tube_model(input logic [7:0] v);
        logic [6:0] tab[16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return {tab[v[7:4]], tab[v[3:0]], 4'b1100};
    endfunction

    // Held-output checks on every cycle the result is expected to be stable.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("led_hold", 32'(led), 32'(led_exp));
            check("tube_hold", 32'(tube), 32'(tube_model(led_exp)));
            if (tx_quiet) check("tx_idle", 32'(uart_tx), 32'(1));
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (DIV) @(negedge sys_clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (DIV) @(negedge sys_clk);
    endtask

    task automatic recv_frame(output logic [7:0] d, output logic ok);
        int n;
        logic s_start, s_stop;
        n  = 0;
        d  = 8'h00;
        ok = 1'b0;
        while (uart_tx !== 1'b0 && n < 12 * DIV + 400) begin
            @(negedge sys_clk);
            n++;
        end
        if (uart_tx !== 1'b0) begin
            check("tx_start_timeout", 32'(uart_tx), 32'(0));
            return;
        end
        repeat (DIV / 2) @(negedge sys_clk);
        s_start = uart_tx;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge sys_clk);
            d[i] = uart_tx;
        end
        repeat (DIV) @(negedge sys_clk);
        s_stop = uart_tx;
        ok = (s_start == 1'b0) && (s_stop == 1'b1);
    endtask

    task automatic run_gcd(input logic [7:0] a, input logic [7:0] b, input logic bad_mid);
        logic [7:0] exp, got;
        logic       ok;
        int         n_lat;
        exp = gcd_model(a, b);
        exp_q.push_back(exp);
        chk_en   = 1'b1;
        tx_quiet = 1'b1;
        send_byte(a, 1'b1);
        if (bad_mid) send_byte(8'h5A, 1'b0);
        chk_en = 1'b0;
        fork
            send_byte(b, 1'b1);
            recv_frame(got, ok);
            begin
                n_lat = 0;
                while (led !== exp && n_lat < 10 * DIV + 300) begin
                    @(negedge sys_clk);
                    n_lat++;
                end
                check("led_latency", 32'(led), 32'(exp));
            end
        join
        check("tx_frame_ok", 32'(ok), 32'(1));
        check("tx_byte", 32'(got), 32'(exp_q.pop_front()));
        check("led_result", 32'(led), 32'(exp));
        check("tube_result", 32'(tube), 32'(tube_model(exp)));
        led_exp = exp;
        chk_en  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n;
        repeat (4) begin
            @(negedge sys_clk);
            check("rst_tx", 32'(uart_tx), 32'(1));
            check("rst_led", 32'(led), 32'(0));
            check("rst_tube", 32'(tube), 32'(18'h2040C));
        end
        #10 reset = 1'b1;
        led_exp = 8'h00;
        chk_en  = 1'b1;
        repeat (20) @(negedge sys_clk);

        run_gcd(8'h08, 8'h10, 1'b0);
        check("lit_led_08", 32'(led), 32'(8'h08));
        check("lit_tube_08", 32'(tube), 32'(18'h2000C));
        run_gcd(8'h0F, 8'h08, 1'b0);
        check("lit_led_01", 32'(led), 32'(8'h01));
        run_gcd(8'h00, 8'h2A, 1'b0);
        check("lit_led_2a", 32'(led), 32'(8'h2A));
        run_gcd(8'hFF, 8'hFF, 1'b0);
        check("lit_tube_ff", 32'(tube), 32'(18'h070EC));

        // Short low pulse must not be taken as a start bit.
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (4 * DIV) @(negedge sys_clk);
        run_gcd(8'h30, 8'h12, 1'b0);
        check("lit_led_06", 32'(led), 32'(8'h06));

        // Framing errors while waiting for the first and second operand.
        send_byte(8'h55, 1'b0);
        run_gcd(8'h24, 8'h18, 1'b0);
        check("lit_led_0c", 32'(led), 32'(8'h0C));
        run_gcd(8'h2A, 8'h1C, 1'b1);
        check("lit_led_0e", 32'(led), 32'(8'h0E));

        run_gcd(8'hFF, 8'h01, 1'b0);
        run_gcd(8'h00, 8'h00, 1'b0);
        check("lit_led_00", 32'(led), 32'(8'h00));
        run_gcd(8'h2A, 8'h00, 1'b0);

        // Reset in the middle of a transmitted frame.
        send_byte(8'h07, 1'b1);
        chk_en = 1'b0;
        seen   = 1'b0;
        fork
            send_byte(8'h07, 1'b1);
            begin
                n = 0;
                while (uart_tx !== 1'b0 && n < 12 * DIV + 400) begin
                    @(negedge sys_clk);
                    n++;
                end
                seen = (uart_tx === 1'b0);
            end
        join_any
        check("tx_active_before_reset", 32'(seen), 32'(1));
        check("led_before_reset", 32'(led), 32'(8'h07));
        @(negedge sys_clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", 32'(uart_tx), 32'(1));
        check("async_rst_led", 32'(led), 32'(0));
        check("async_rst_tube", 32'(tube), 32'(18'h2040C));
        #20 reset = 1'b1;
        led_exp = 8'h00;
        chk_en  = 1'b1;
        repeat (3 * DIV) @(negedge sys_clk);
        run_gcd(8'h1B, 8'h12, 1'b0);
        check("lit_led_09", 32'(led), 32'(8'h09));
        run_gcd(8'h64, 8'h4B, 1'b0);
        check("lit_led_19", 32'(led), 32'(8'h19));

        chk_en = 1'b0;
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
